// File: rtl/gate_tester_pkg.sv
// gate_tester_pkg: shared types and constants for the gate tester.
//   state_e       - sweep FSM states
//   GATE_*        - bit positions of each gate output within the 8-bit bus
//   NUM_VEC       - number of input vectors in a sweep ({a,b} = 0..3)
//   popcnt8()     - population count used by the optional error counter
package gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_ANOT = 3;
  localparam int GATE_BNOT = 4;
  localparam int GATE_NAND = 5;
  localparam int GATE_NOR  = 6;
  localparam int GATE_XNOR = 7;

  localparam int NUM_GATES = 8;
  localparam int NUM_VEC   = 4;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/gate_tester_fsm_ref.sv
// gate_ref_model: combinational golden model of the two-input gate unit.
//   a_i, b_i : gate unit inputs
//   exp_o    : expected 8-bit output, same packing as gate_in of the tester
module gate_ref_model
  import gate_tester_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);

  always_comb begin
    exp_o            = '0;
    exp_o[GATE_AND]  = a_i & b_i;
    exp_o[GATE_OR]   = a_i | b_i;
    exp_o[GATE_XOR]  = a_i ^ b_i;
    exp_o[GATE_ANOT] = ~a_i;
    exp_o[GATE_BNOT] = ~b_i;
    exp_o[GATE_NAND] = ~(a_i & b_i);
    exp_o[GATE_NOR]  = ~(a_i | b_i);
    exp_o[GATE_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_tester_fsm.sv
// gate_tester_fsm: sweeps the gate unit through {a,b} = 00,01,10,11, holds
// each vector SETTLE_CYCLES cycles, samples gate_in and compares it against
// gate_ref_model.
//   clk_in, rstn_in   - clock, synchronous active-low reset
//   start_in          - begin a sweep (only looked at in IDLE)
//   gate_in[7:0]      - gate unit outputs
//   a_out, b_out      - gate unit inputs
//   busy_out          - sweep in progress (start acceptance .. DONE left)
//   done_out          - one-cycle end-of-sweep pulse
//   pass_out          - last sweep had no mismatches
//   fault_map_out     - per-output sticky mismatch map
//   fail_vec_out      - per-vector mismatch map
//   err_cnt_out       - total mismatching bits (only with GATE_TESTER_ERRCNT_EN)
// SETTLE_CYCLES legal range is 1..15.
module gate_tester_fsm
  import gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       start_in,
  input  logic [7:0] gate_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [7:0] fault_map_out,
  output logic [3:0] fail_vec_out
`ifdef GATE_TESTER_ERRCNT_EN
  ,
  output logic [5:0] err_cnt_out
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] VEC_LAST = 2'(NUM_VEC - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] fault_q, fault_d;
  logic [3:0] failv_q, failv_d;
  logic [5:0] err_q, err_d;

  logic [7:0] exp_vec;
  logic [7:0] diff;

  // vec_q equals the driven {a,b} whenever a sample is taken
  gate_ref_model u_ref (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_vec)
  );

  assign diff = gate_in ^ exp_vec;

  // state register
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      ST_SAMPLE: begin
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output / result next values; everything lands in registers so no
  // input reaches an output combinationally
  always_comb begin
    ab_d    = (state_d == ST_SETTLE || state_d == ST_SAMPLE) ? vec_d : 2'b00;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_DONE);
    pass_d  = pass_q;
    fault_d = fault_q;
    failv_d = failv_q;
    err_d   = err_q;
    if (state_q == ST_IDLE && start_in) begin
      pass_d  = 1'b0;
      fault_d = '0;
      failv_d = '0;
      err_d   = '0;
    end
    if (state_q == ST_SAMPLE) begin
      fault_d        = fault_q | diff;
      failv_d[vec_q] = failv_q[vec_q] | (|diff);
      err_d          = err_q + {2'b00, popcnt8(diff)};
    end
    // fault_q already holds the last sample by the time DONE is reached
    if (state_q == ST_DONE) pass_d = (fault_q == 8'h00);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fault_q <= '0;
      failv_q <= '0;
      err_q   <= '0;
    end else begin
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fault_q <= fault_d;
      failv_q <= failv_d;
      err_q   <= err_d;
    end
  end

  assign a_out         = ab_q[1];
  assign b_out         = ab_q[0];
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign pass_out      = pass_q;
  assign fault_map_out = fault_q;
  assign fail_vec_out  = failv_q;

`ifdef GATE_TESTER_ERRCNT_EN
  assign err_cnt_out = err_q;
`else
  // counter unused in this build; tie off so it is optimised away
  logic err_unused;
  assign err_unused = ^err_q;
`endif

endmodule

// File: tb/tb_gate_tester_fsm.sv
`timescale 1ns/1ps
module tb_gate_tester_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start0, start1;
  logic [7:0] g0, g1;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [7:0] fm0, fm1;
  logic [3:0] fv0, fv1;
  logic [5:0] ec0, ec1;

  int n_cmp = 0;
  int n_fail = 0;

  // fault injection: 0 good, 1 and stuck-at-1, 2 anot/bnot swapped, 3 xor mask per vector
  int mode = 0;
  logic [7:0] mask [4];

  gate_tester_fsm #(.SETTLE_CYCLES(2)) dut0 (
    .clk_in(clk), .rstn_in(rstn), .start_in(start0), .gate_in(g0),
    .a_out(a0), .b_out(b0), .busy_out(busy0), .done_out(done0), .pass_out(pass0),
    .fault_map_out(fm0), .fail_vec_out(fv0)
`ifdef GATE_TESTER_ERRCNT_EN
    , .err_cnt_out(ec0)
`endif
  );

  gate_tester_fsm #(.SETTLE_CYCLES(1)) dut1 (
    .clk_in(clk), .rstn_in(rstn), .start_in(start1), .gate_in(g1),
    .a_out(a1), .b_out(b1), .busy_out(busy1), .done_out(done1), .pass_out(pass1),
    .fault_map_out(fm1), .fail_vec_out(fv1)
`ifdef GATE_TESTER_ERRCNT_EN
    , .err_cnt_out(ec1)
`endif
  );

`ifndef GATE_TESTER_ERRCNT_EN
  assign ec0 = '0;
  assign ec1 = '0;
`endif

  function automatic logic [7:0] good(input logic a, input logic b);
    return {~(a ^ b), ~(a | b), ~(a & b), ~b, ~a, a ^ b, a | b, a & b};
  endfunction

  function automatic logic [7:0] unit(input logic a, input logic b, input int md, input logic [7:0] m);
    logic [7:0] v;
    v = good(a, b);
    case (md)
      1: v[0] = 1'b1;
      2: begin v[3] = ~b; v[4] = ~a; end
      3: v = v ^ m;
      default: ;
    endcase
    return v;
  endfunction

  always_comb g0 = unit(a0, b0, mode, mask[{a0, b0}]);
  always_comb g1 = unit(a1, b1, mode, mask[{a1, b1}]);

  // expected sweep results for the current fault setup
  logic [7:0] x_fm;
  logic [3:0] x_fv;
  logic       x_pass;
  logic [5:0] x_err;

  task automatic model();
    logic [7:0] d;
    x_fm = '0; x_fv = '0; x_err = '0;
    for (int k = 0; k < 4; k++) begin
      d = unit(k[1], k[0], mode, mask[k]) ^ good(k[1], k[0]);
      x_fm = x_fm | d;
      x_fv[k] = (d != 0);
      x_err = x_err + 6'($countones(d));
    end
    x_pass = (x_fm == 0);
  endtask

  // runs one sweep and returns what the DUT reported; lat = edges after the accepting edge
  task automatic sweep(input int sel, output int lat, output logic [7:0] fm, output logic [3:0] fv,
                       output logic ps, output logic [5:0] ec, output logic dn_after);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    lat = -1;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if ((sel == 1) ? done1 : done0) begin lat = j - 1; break; end
    end
    fm = (sel == 1) ? fm1 : fm0;
    fv = (sel == 1) ? fv1 : fv0;
    ps = (sel == 1) ? pass1 : pass0;
    ec = (sel == 1) ? ec1 : ec0;
    @(negedge clk);
    dn_after = (sel == 1) ? done1 : done0;
  endtask

  int lat;
  logic [7:0] o_fm;
  logic [3:0] o_fv;
  logic o_ps, o_dn;
  logic [5:0] o_ec;

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a0, b0, busy0, done0, pass0, fm0, fv0, ec0} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut0 got %h want 0", {a0, b0, busy0, done0, pass0, fm0, fv0, ec0});
    end
    n_cmp++;
    if ({a1, b1, busy1, done1, pass1, fm1, fv1, ec1} !== 20'h0) begin
      n_fail++; $display("FAIL reset_dut1 got %h want 0", {a1, b1, busy1, done1, pass1, fm1, fv1, ec1});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed(input string nm, input int sel, input int md, input int w_lat,
                            input logic [7:0] w_fm, input logic [3:0] w_fv, input logic w_ps,
                            input logic [5:0] w_ec);
    mode = md;
    sweep(sel, lat, o_fm, o_fv, o_ps, o_ec, o_dn);
    n_cmp++; if (lat !== w_lat) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", nm, lat, w_lat); end
    n_cmp++; if (o_fm !== w_fm) begin n_fail++; $display("FAIL %s_fault_map got %h want %h", nm, o_fm, w_fm); end
    n_cmp++; if (o_fv !== w_fv) begin n_fail++; $display("FAIL %s_fail_vec got %b want %b", nm, o_fv, w_fv); end
    n_cmp++; if (o_ps !== w_ps) begin n_fail++; $display("FAIL %s_pass got %b want %b", nm, o_ps, w_ps); end
    n_cmp++; if (o_dn !== 1'b0) begin n_fail++; $display("FAIL %s_done_width done still %b a cycle later", nm, o_dn); end
`ifdef GATE_TESTER_ERRCNT_EN
    n_cmp++; if (o_ec !== w_ec) begin n_fail++; $display("FAIL %s_err_cnt got %0d want %0d", nm, o_ec, w_ec); end
`endif
  endtask

  task automatic test_random();
    int sel, w_lat;
    for (int it = 0; it < 10; it++) begin
      mode = 3;
      for (int k = 0; k < 4; k++) mask[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      model();
      sel = it % 2;
      w_lat = (sel == 1) ? 9 : 13;
      sweep(sel, lat, o_fm, o_fv, o_ps, o_ec, o_dn);
      n_cmp++; if (lat !== w_lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, w_lat); end
      n_cmp++; if (o_fm !== x_fm) begin n_fail++; $display("FAIL rand%0d_fault_map got %h want %h", it, o_fm, x_fm); end
      n_cmp++; if (o_fv !== x_fv) begin n_fail++; $display("FAIL rand%0d_fail_vec got %b want %b", it, o_fv, x_fv); end
      n_cmp++; if (o_ps !== x_pass) begin n_fail++; $display("FAIL rand%0d_pass got %b want %b", it, o_ps, x_pass); end
`ifdef GATE_TESTER_ERRCNT_EN
      n_cmp++; if (o_ec !== x_err) begin n_fail++; $display("FAIL rand%0d_err_cnt got %0d want %0d", it, o_ec, x_err); end
`endif
    end
    mode = 0;
  endtask

  task automatic test_ignored_start();
    int npulse, first;
    mode = 0; npulse = 0; first = -1;
    @(negedge clk); start0 = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      start0 = ((j - 1) == 3 || (j - 1) == 7) ? 1'b1 : 1'b0;
      if (done0) begin npulse++; if (first < 0) first = j - 1; end
    end
    start0 = 1'b0;
    n_cmp++; if (npulse !== 1) begin n_fail++; $display("FAIL ignored_start_pulses got %0d want 1", npulse); end
    n_cmp++; if (first !== 13) begin n_fail++; $display("FAIL ignored_start_done_cycle got %0d want 13", first); end
  endtask

  task automatic test_reset_mid();
    int nd;
    mode = 3;
    for (int k = 0; k < 4; k++) mask[k] = 8'hA5;
    nd = 0;
    @(negedge clk); start0 = 1'b1;
    for (int j = 1; j <= 5; j++) begin @(negedge clk); start0 = 1'b0; end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a0, b0, busy0, done0, pass0, fm0, fv0, ec0} !== 20'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs got %h want 0", {a0, b0, busy0, done0, pass0, fm0, fv0, ec0});
    end
    rstn = 1'b1;
    for (int j = 0; j < 20; j++) begin @(negedge clk); if (done0) nd++; end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d pulses want 0", nd); end
    test_fixed("after_reset", 0, 0, 13, 8'h00, 4'b0000, 1'b1, 6'd0);
  endtask

  task automatic test_back_to_back();
    test_fixed("b2b_first", 0, 1, 13, 8'h01, 4'b0111, 1'b0, 6'd3);
    mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n_cmp++;
    if ({pass0, fm0, fv0, ec0} !== 19'h0) begin
      n_fail++; $display("FAIL b2b_cleared got %h want 0", {pass0, fm0, fv0, ec0});
    end
    n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy0); end
    for (int j = 0; j < 40 && !done0; j++) @(negedge clk);
    n_cmp++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done0); end
    n_cmp++; if ({pass0, fm0, fv0} !== 13'h1000) begin
      n_fail++; $display("FAIL b2b_second_result got pass=%b fm=%h fv=%b want pass=1 fm=00 fv=0000", pass0, fm0, fv0);
    end
    @(negedge clk);
  endtask

  task automatic test_held_start();
    int d1, d2;
    mode = 0; d1 = -1; d2 = -1;
    @(negedge clk); start0 = 1'b1;
    for (int j = 1; j <= 60 && d2 < 0; j++) begin
      @(negedge clk);
      if (done0) begin if (d1 < 0) d1 = j - 1; else d2 = j - 1; end
    end
    start0 = 1'b0;
    n_cmp++; if (d1 !== 13) begin n_fail++; $display("FAIL held_first_done got %0d want 13", d1); end
    n_cmp++; if (d2 - d1 !== 14) begin n_fail++; $display("FAIL held_restart_period got %0d want 14", d2 - d1); end
    for (int j = 0; j < 40 && busy0; j++) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL held_idle busy got %b want 0", busy0); end
    @(negedge clk);
  endtask

  initial begin
    start0 = 1'b0; start1 = 1'b0; rstn = 1'b0;
    for (int k = 0; k < 4; k++) mask[k] = 8'h00;
    test_reset();
    test_fixed("fault_free", 0, 0, 13, 8'h00, 4'b0000, 1'b1, 6'd0);
    test_fixed("and_stuck1", 0, 1, 13, 8'h01, 4'b0111, 1'b0, 6'd3);
    test_fixed("not_swap_s1", 1, 2, 9, 8'h18, 4'b0110, 1'b0, 6'd4);
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_held_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
